// File: rtl/uart_transceiver_if.sv
// Byte-side and serial-side signals of uart_transceiver.
// slave is the transceiver's view; master is the host/pin side that drives it.
interface uart_transceiver_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;

    modport master (
        output i_Rx_Serial, i_Tx_DV, i_Tx_Byte,
        input  o_Rx_DV, o_Rx_Byte, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );

    modport slave (
        input  i_Rx_Serial, i_Tx_DV, i_Tx_Byte,
        output o_Rx_DV, o_Rx_Byte, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with independent Rx and Tx state machines on one clock.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer on the receive line.
module uart_transceiver #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    uart_transceiver_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_CLEANUP
    } state_t;

    logic rx_sync;

`ifdef UART_RX_SYNC_EN
    logic rx_meta;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end
`else
    always_ff @(posedge i_Clock) begin
        if (i_Reset) rx_sync <= 1'b1;
        else         rx_sync <= bus.i_Rx_Serial;
    end
`endif

    // ---------------- receiver ----------------
    state_t           rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             rx_dv, rx_dv_n;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_dv    <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_byte  <= rx_byte_n;
            rx_dv    <= rx_dv_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte;
        rx_dv_n    = 1'b0;
        unique case (rx_state)
            ST_IDLE: begin
                rx_cnt_n = '0;
                rx_idx_n = '0;
                if (!rx_sync) rx_state_n = ST_START;
            end
            ST_START: begin
                // Half a bit in: a line that has returned high was only a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n           = '0;
                    rx_shift_n[rx_idx] = rx_sync;
                    if (rx_idx == 3'd7) begin
                        rx_idx_n   = '0;
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_CLEANUP;
                    if (rx_sync) begin
                        rx_byte_n = rx_shift;
                        rx_dv_n   = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            ST_CLEANUP: rx_state_n = ST_IDLE;
            default:    rx_state_n = ST_IDLE;
        endcase
    end

    assign bus.o_Rx_DV   = rx_dv;
    assign bus.o_Rx_Byte = rx_byte;

    // ---------------- transmitter ----------------
    state_t           tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [7:0]       tx_data, tx_data_n;
    logic             tx_serial, tx_serial_n;
    logic             tx_active, tx_active_n;
    logic             tx_done, tx_done_n;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_idx    <= tx_idx_n;
            tx_data   <= tx_data_n;
            tx_serial <= tx_serial_n;
            tx_active <= tx_active_n;
            tx_done   <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_idx_n    = tx_idx;
        tx_data_n   = tx_data;
        tx_active_n = tx_active;
        tx_done_n   = 1'b0;
        unique case (tx_state)
            ST_IDLE: begin
                tx_cnt_n = '0;
                tx_idx_n = '0;
                if (bus.i_Tx_DV) begin
                    tx_data_n   = bus.i_Tx_Byte;
                    tx_active_n = 1'b1;
                    tx_state_n  = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = ST_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == 3'd7) begin
                        tx_idx_n   = '0;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n    = '0;
                    tx_done_n   = 1'b1;
                    tx_active_n = 1'b0;
                    tx_state_n  = ST_CLEANUP;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            ST_CLEANUP: tx_state_n = ST_IDLE;
            default:    tx_state_n = ST_IDLE;
        endcase

        // Line level is decoded from the next state so the pin comes straight off a flop.
        unique case (tx_state_n)
            ST_START: tx_serial_n = 1'b0;
            ST_DATA:  tx_serial_n = tx_data_n[tx_idx_n];
            default:  tx_serial_n = 1'b1;
        endcase
    end

    assign bus.o_Tx_Serial = tx_serial;
    assign bus.o_Tx_Active = tx_active;
    assign bus.o_Tx_Done   = tx_done;
endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: directed cases, loopback, mid-frame
// reset and a randomized full-duplex phase against a frame-level model.
module tb_uart_transceiver;
    localparam int unsigned C       = 87;
    localparam int unsigned FRAME_N = 10 * C + 2;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic drv_rx  = 1'b1;
    logic loop_en = 1'b0;
    int   cyc     = 0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int tx_pushed  = 0;
    int tx_flushed = 0;
    int rx_pushed  = 0;
    int rx_flushed = 0;
    int done_seen  = 0;
    int dv_seen    = 0;
    int tx_free    = 0;
    logic [7:0] last_rx = 8'h00;

    logic line_s [FRAME_N];
    logic act_s  [FRAME_N];
    logic done_s [FRAME_N];
    bit   tx_aborted;

    uart_transceiver_if bus();

    uart_transceiver #(.CLKS_PER_BIT(C)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    assign bus.i_Rx_Serial = loop_en ? bus.o_Tx_Serial : drv_rx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a request is taken only if the transmitter is free at the sampling edge;
    // a frame occupies 10 bit periods plus the pulse and cleanup cycles.
    task automatic tx_send(input logic [7:0] b);
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = b;
        if (cyc + 1 >= tx_free) begin
            exp_tx.push_back(b);
            tx_pushed++;
            if (loop_en) begin
                exp_rx.push_back(b);
                rx_pushed++;
                last_rx = b;
            end
            tx_free = cyc + 1 + 10 * C + 2;
        end
        tick(1);
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'($urandom);
    endtask

    task automatic wait_tx_free();
        while (cyc + 1 < tx_free) tick(1);
    endtask

    task automatic drive_bit(input logic v);
        drv_rx = v;
        tick(C);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic good_stop, input int abort_bit);
        if (good_stop && abort_bit > 8) begin
            exp_rx.push_back(b);
            rx_pushed++;
            last_rx = b;
        end
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == abort_bit) begin
                drv_rx = b[k];
                tick(C / 2);
                return;
            end
            drive_bit(b[k]);
        end
        drive_bit(good_stop);
        drv_rx = 1'b1;
    endtask

    task automatic tx_judge();
        logic [7:0] e;
        logic [7:0] got;
        logic [9:0] fr;
        int bad_shape;
        int bad_ctrl;
        check("tx_frame_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() == 0) return;
        e  = exp_tx.pop_front();
        fr = {1'b1, e, 1'b0};
        for (int k = 0; k < 8; k++) got[k] = line_s[(k + 1) * C + C / 2];
        check("tx_byte", got, e);
        bad_shape = 0;
        for (int i = 0; i < 10 * C; i++)
            if (line_s[i] !== fr[i / C]) bad_shape++;
        check("tx_bit_timing", bad_shape, 0);
        bad_ctrl = 0;
        for (int i = 0; i < 10 * C; i++)
            if (act_s[i] !== 1'b1 || done_s[i] !== 1'b0) bad_ctrl++;
        if (act_s[10 * C] !== 1'b0 || done_s[10 * C] !== 1'b1) bad_ctrl++;
        if (act_s[10 * C + 1] !== 1'b0 || done_s[10 * C + 1] !== 1'b0) bad_ctrl++;
        check("tx_active_done", bad_ctrl, 0);
    endtask

    // Tx monitor: captures a whole frame from its falling edge, then scores it.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.o_Tx_Serial === 1'b0) begin
            tx_aborted = 1'b0;
            for (int i = 0; i < FRAME_N; i++) begin
                if (i > 0) @(negedge clk);
                if (rst) begin
                    tx_aborted = 1'b1;
                    break;
                end
                line_s[i] = bus.o_Tx_Serial;
                act_s[i]  = bus.o_Tx_Active;
                done_s[i] = bus.o_Tx_Done;
            end
            if (!tx_aborted) tx_judge();
        end
    end

    // Rx monitor
    initial forever begin
        @(negedge clk);
        if (bus.o_Rx_DV === 1'b1) begin
            check("rx_dv_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) check("rx_byte", bus.o_Rx_Byte, exp_rx.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus.o_Tx_Done === 1'b1) done_seen++;
        if (bus.o_Rx_DV === 1'b1)   dv_seen++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: cycle budget exhausted, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'h00;
        rst = 1'b1;
        tick(3);
        check("rst_tx_serial", bus.o_Tx_Serial, 1);
        check("rst_tx_active", bus.o_Tx_Active, 0);
        check("rst_tx_done",   bus.o_Tx_Done, 0);
        check("rst_rx_dv",     bus.o_Rx_DV, 0);
        check("rst_rx_byte",   bus.o_Rx_Byte, 8'h00);
        rst = 1'b0;
        tick(2);

        tx_send(8'hAB);
        wait_tx_free();
        tick(C);

        rx_frame(8'h3F, 1'b1, 9);
        tick(C);
        check("rx_hold_3f", bus.o_Rx_Byte, 8'h3F);

        drv_rx = 1'b0;
        tick(20);
        drv_rx = 1'b1;
        tick(2 * C);
        check("rx_glitch_hold", bus.o_Rx_Byte, 8'h3F);
        rx_frame(8'h55, 1'b1, 9);
        tick(C);
        check("rx_after_glitch", bus.o_Rx_Byte, 8'h55);

        rx_frame(8'hC3, 1'b0, 9);
        tick(2 * C);
        check("rx_framing_hold", bus.o_Rx_Byte, 8'h55);

        loop_en = 1'b1;
        tick(2);
        tx_send(8'h00);
        tick(5 * C);
        tx_send(8'h77);
        wait_tx_free();
        tx_send(8'hFF);
        wait_tx_free();
        tx_send(8'hA5);
        wait_tx_free();
        tick(2 * C);
        check("loop_last_byte", bus.o_Rx_Byte, 8'hA5);
        loop_en = 1'b0;
        tick(2);

        // Tx lands in bit 3 (low for 8'hC3) while Rx is halfway through bit 5.
        fork
            rx_frame(8'h96, 1'b1, 5);
            begin
                tick(2 * C);
                tx_send(8'hC3);
            end
        join
        rst = 1'b1;
        tx_flushed += exp_tx.size();
        exp_tx.delete();
        rx_flushed += exp_rx.size();
        exp_rx.delete();
        tx_free = 0;
        drv_rx  = 1'b1;
        tick(1);
        check("midrst_tx_serial", bus.o_Tx_Serial, 1);
        check("midrst_tx_active", bus.o_Tx_Active, 0);
        check("midrst_tx_done",   bus.o_Tx_Done, 0);
        check("midrst_rx_dv",     bus.o_Rx_DV, 0);
        check("midrst_rx_byte",   bus.o_Rx_Byte, 8'h00);
        rst = 1'b0;
        tick(2);
        loop_en = 1'b1;
        tx_send(8'h3C);
        wait_tx_free();
        tick(2 * C);
        check("post_rst_byte", bus.o_Rx_Byte, 8'h3C);
        loop_en = 1'b0;
        tick(2);

        fork
            begin : rx_rand
                logic [7:0] b;
                logic       good;
                for (int n = 0; n < 12; n++) begin
                    b    = 8'($urandom);
                    good = ($urandom_range(0, 5) != 0);
                    rx_frame(b, good, 9);
                    if (good) tick(int'($urandom_range(1, 2 * C)));
                    else      tick(C + int'($urandom_range(1, C)));
                end
            end
            begin : tx_rand
                for (int n = 0; n < 12; n++) begin
                    tick(int'($urandom_range(1, 12 * C)));
                    tx_send(8'($urandom));
                end
            end
        join
        wait_tx_free();
        tick(2 * C);
        check("rand_rx_hold", bus.o_Rx_Byte, last_rx);

        check("tx_queue_drained", exp_tx.size(), 0);
        check("rx_queue_drained", exp_rx.size(), 0);
        check("tx_done_pulses", done_seen, tx_pushed - tx_flushed);
        check("rx_dv_pulses",   dv_seen,   rx_pushed - rx_flushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first. It contains an independent receiver path and transmitter path that share one clock. The bit period is a fixed number of clocks set by a parameter (e.g. 50 MHz / 9600 baud = 5208). It sits between the FPGA serial pins and the byte-level host logic.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit; legal range >= 4.

Ports:
i_Clock  input  1  system clock; all logic on its rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Rx_Serial  input  1  serial receive line; idles high.
o_Rx_DV  output  1  one-cycle pulse; o_Rx_Byte is valid and new.
o_Rx_Byte  output  8  last received byte.
i_Tx_DV  input  1  one-cycle request to start sending i_Tx_Byte.
i_Tx_Byte  input  8  byte to transmit; sampled when i_Tx_DV is accepted.
o_Tx_Active  output  1  high while a frame is being transmitted.
o_Tx_Serial  output  1  serial transmit line; idles high.
o_Tx_Done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (synchronous, i_Reset=1 at a clock edge):
  - Both FSMs go to IDLE; all counters are cleared.
  - Output values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=8'h00.
  - Reset asserted mid-frame aborts the frame immediately. The tx line returns high the next cycle; no Done or DV pulse is produced.
- Receiver FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: wait for the line to read 0.
  - START: count (CLKS_PER_BIT-1)/2 clocks, then re-sample.
    - Line still 0: clear the counter, go to DATA.
    - Line 1: treat as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT clocks, sample one bit into index 0..7 (LSB first). After bit 7, go to STOP.
  - STOP: wait CLKS_PER_BIT clocks, then sample.
    - Line 1: update o_Rx_Byte and pulse o_Rx_DV for exactly one cycle.
    - Line 0 (framing error): discard the byte; no DV pulse, o_Rx_Byte is unchanged.
  - CLEANUP: one cycle, then IDLE.
  - o_Rx_Byte holds its value until the next valid frame.
- Transmitter FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: o_Tx_Serial=1. When i_Tx_DV=1, latch i_Tx_Byte, set o_Tx_Active=1, go to START.
  - START: drive 0 for CLKS_PER_BIT clocks.
  - DATA: drive bits 0..7, each for CLKS_PER_BIT clocks.
  - STOP: drive 1 for CLKS_PER_BIT clocks. On the final clock of the stop bit, set o_Tx_Done=1 and o_Tx_Active=0.
  - CLEANUP: one cycle, o_Tx_Done stays 1; then IDLE with o_Tx_Done=0.
  - i_Tx_DV outside IDLE is ignored, and changes to i_Tx_Byte mid-frame have no effect.
  - The next frame can start from IDLE on the cycle after CLEANUP.
- Timing:
  - Tx frame length is 10*CLKS_PER_BIT + 2 clocks from DV acceptance to IDLE.
  - Rx DV is asserted about 9.5 bit periods after the falling start edge, plus the synchronizer delay.
- Rx and Tx are fully independent. Simultaneous activity, including loopback of o_Tx_Serial to i_Rx_Serial, must work.
- Counters must be wide enough for CLKS_PER_BIT-1, using $clog2.

Optional Feature:
UART_RX_SYNC_EN:
- Defined: i_Rx_Serial passes through a two-flop synchronizer (reset value 1) before the Rx FSM. This adds 2 clocks of latency to start detection and to o_Rx_DV.
- Undefined: i_Rx_Serial feeds the FSM through a single register (reset value 1), for 1 clock of latency.
- Framing and byte results are identical in both builds.

Test Plan:
- Tx, CLKS_PER_BIT=87: pulse i_Tx_DV with 8'hAB -> o_Tx_Serial sequence is 0,1,1,0,1,0,1,0,1,1, each bit 87 clocks; o_Tx_Active high throughout; one o_Tx_Done pulse; line returns high.
- Rx: drive 8'h3F serially at 87 clocks/bit -> one o_Rx_DV pulse with o_Rx_Byte=8'h3F; the byte is held afterwards.
- Rx glitch: drive the line low for 20 clocks, then high -> no DV, FSM back in IDLE; a following valid 8'h55 frame is received correctly.
- Framing error: send 8'hC3 with the stop bit held 0 -> no o_Rx_DV, o_Rx_Byte unchanged.
- Loopback: tie o_Tx_Serial to i_Rx_Serial, send 8'h00, 8'hFF, 8'hA5 back-to-back, with i_Tx_DV also pulsed mid-frame -> received bytes 00, FF, A5; the mid-frame request is ignored.
- Reset mid-frame: assert i_Reset during Tx bit 3 and Rx bit 5 -> next cycle o_Tx_Serial=1, o_Tx_Active=0, no Done or DV pulses; a subsequent 8'h3C transfer succeeds.
